// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches words over a req/ack
// handshake into a small FIFO, presents the head word to decode and applies
// jr / j / taken-branch redirects when the head instruction is consumed.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        pc_src,
   input  logic        jctrl,
   input  logic        jrctrl,
   input  logic [31:0] jr_addr,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  func,
   output logic [31:0] instr_pc,
   output logic [31:0] pc_plus4
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH = CNT_W'(BUF_DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [31:0]       fetch_pc, fetch_pc_nxt;
   logic [31:0]       drop_addr;
   logic [31:0]       buf_word [BUF_DEPTH];
   logic [31:0]       buf_pc   [BUF_DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [CNT_W-1:0]  count, count_nxt;
   logic              take, redirect, push;
   logic [31:0]       head_word, head_pc, head_plus4, br_off, target;

   // Head of the buffer and redirect target selection (jr > j > branch)
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      head_word  = buf_word[rd_ptr];
      head_pc    = buf_pc[rd_ptr];
      head_plus4 = head_pc + 32'd4;
      br_off     = {{14{head_word[15]}}, head_word[15:0], 2'b00};
      target     = head_plus4 + br_off;
      if (jrctrl) begin
         target = jr_addr;
      end else if (jctrl) begin
         target = {head_plus4[31:28], head_word[25:0], 2'b00};
      end
   end

   assign instr_valid = (count != '0);
   assign take        = instr_valid && !stall;
   assign redirect    = take && (jrctrl || jctrl || pc_src);
   assign push        = (state == REQ) && imem_ack && !redirect;

   assign instr    = instr_valid ? head_word : 32'd0;
   assign instr_pc = instr_valid ? head_pc   : 32'd0;
   assign pc_plus4 = instr_pc + 32'd4;
   assign opcode   = instr[31:26];
   assign func     = instr[5:0];

   assign imem_req  = (state != IDLE);
   assign imem_addr = (state == DROP) ? drop_addr : fetch_pc;

   // Buffer occupancy after this edge: a redirect flushes, otherwise push/pop
   always_comb begin
      count_nxt = count;
      if (redirect) begin
         count_nxt = '0;
      end else begin
         count_nxt = count + CNT_W'(push) - CNT_W'(take);
      end
   end

   // Fetch FSM next-state and fetch PC update
   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      unique case (state)
         IDLE: begin
            if (redirect) fetch_pc_nxt = target;
            if (count < DEPTH) state_nxt = REQ;
         end
         REQ: begin
            if (redirect) begin
               // A request cannot be withdrawn: without ack, wait it out in DROP
               fetch_pc_nxt = target;
               state_nxt    = imem_ack ? REQ : DROP;
            end else if (imem_ack) begin
               fetch_pc_nxt = fetch_pc + 32'd4;
               state_nxt    = (count_nxt < DEPTH) ? REQ : IDLE;
            end
         end
         DROP: begin
            if (redirect) fetch_pc_nxt = target;
            if (imem_ack) state_nxt = REQ;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state, fetch PC and the address of a request being discarded
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         drop_addr <= RESET_PC;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         if ((state == REQ) && (state_nxt == DROP)) drop_addr <= fetch_pc;
      end
   end

   // FIFO pointers and occupancy count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         count <= count_nxt;
         if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (take) rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // FIFO storage: instruction word and its fetch address
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; its contents are only visible while count marks them valid.
      if (push) begin
         buf_word[wr_ptr] <= imem_rdata;
         buf_pc[wr_ptr]   <= fetch_pc;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory responder with programmable
// ack latency, a scoreboard of expected (pc, word) takes, a table of redirect
// vectors and hand-written sequences for stall, outstanding-request and reset.
module tb_instr_fetch_unit;

   logic        clk, rst;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        stall, pc_src, jctrl, jrctrl;
   logic [31:0] jr_addr;
   logic        instr_valid;
   logic [31:0] instr, instr_pc, pc_plus4;
   logic [5:0]  opcode, func;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .pc_src(pc_src), .jctrl(jctrl), .jrctrl(jrctrl),
      .jr_addr(jr_addr),
      .instr_valid(instr_valid), .instr(instr),
      .opcode(opcode), .func(func),
      .instr_pc(instr_pc), .pc_plus4(pc_plus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;
   int sb_pops = 0;
   int mem_lat = 1;
   logic [31:0] ovr_addr = 32'hFFFF_FFFF;
   logic [31:0] ovr_word = 32'd0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
      logic        src;
      logic        j;
      logic        jr;
      logic [31:0] jra;
      logic [31:0] exp;
      int          lat;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == ovr_addr) return ovr_word;
      return {8'hA5, a[23:0]};
   endfunction

   task automatic sb_push(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.word = mem_word(pc);
      sb_q.push_back(e);
   endtask

   // Instruction memory: ack mem_lat cycles after a request becomes visible
   initial begin : mem_model
      int cnt;
      cnt = 0;
      imem_ack = 1'b0;
      imem_rdata = 32'd0;
      forever begin
         @(posedge clk); #1;
         if (imem_req) begin
            if (cnt >= mem_lat - 1) begin
               imem_ack   = 1'b1;
               imem_rdata = mem_word(imem_addr);
               cnt = 0;
            end else begin
               imem_ack = 1'b0;
               cnt++;
            end
         end else begin
            imem_ack = 1'b0;
            cnt = 0;
         end
      end
   end

   // Scoreboard of takes and request-stability monitor
   logic        p_ok, p_req, p_ack;
   logic [31:0] p_addr;
   initial begin : monitor
      exp_t e;
      p_ok = 1'b0; p_req = 1'b0; p_ack = 1'b0; p_addr = 32'd0;
      forever begin
         @(negedge clk);
         if (rst && instr_valid && !stall) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL sb_unexpected_take: got pc %h, expected no take", instr_pc);
            end else begin
               e = sb_q.pop_front();
               sb_pops++;
               check("sb_pc", instr_pc, e.pc);
               check("sb_word", instr, e.word);
            end
         end
         if (rst && p_ok && p_req && !p_ack) begin
            check("req_held", {31'd0, imem_req}, 32'd1);
            check("addr_stable", imem_addr, p_addr);
         end
         p_ok = rst; p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      end
   end

   task automatic do_reset();
      rst = 1'b0;
      stall = 1'b1; pc_src = 1'b0; jctrl = 1'b0; jrctrl = 1'b0; jr_addr = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_pc", instr_pc, 32'd0);
      sb_q.delete();
      sb_pops = 0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (instr_valid) return;
      end
      check(name, {31'd0, instr_valid}, 32'd1);
   endtask

   task automatic take_head(input logic s, input logic j, input logic jr, input logic [31:0] ja);
      wait_valid("take_wait_valid");
      stall = 1'b0; pc_src = s; jctrl = j; jrctrl = jr; jr_addr = ja;
      @(posedge clk); #1;
      stall = 1'b1; pc_src = 1'b0; jctrl = 1'b0; jrctrl = 1'b0; jr_addr = 32'd0;
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int held;
      rst = 1'b0;
      stall = 1'b1; pc_src = 1'b0; jctrl = 1'b0; jrctrl = 1'b0; jr_addr = 32'd0;

      vecs[0] = '{pc: 32'h0000_0010, word: 32'h1022_FFFC, src: 1, j: 0, jr: 0, jra: 32'h0,        exp: 32'h0000_0004, lat: 1};
      vecs[1] = '{pc: 32'h2000_0040, word: 32'h0800_0100, src: 0, j: 1, jr: 0, jra: 32'h0,        exp: 32'h2000_0400, lat: 2};
      vecs[2] = '{pc: 32'h0000_0050, word: 32'h0800_0100, src: 0, j: 1, jr: 1, jra: 32'h80,       exp: 32'h0000_0080, lat: 3};
      vecs[3] = '{pc: 32'h0000_0100, word: 32'h1000_0003, src: 1, j: 0, jr: 0, jra: 32'h0,        exp: 32'h0000_0110, lat: 1};
      vecs[4] = '{pc: 32'h0000_0040, word: 32'h0BFF_FFFF, src: 1, j: 1, jr: 0, jra: 32'h0,        exp: 32'h0FFF_FFFC, lat: 2};
      vecs[5] = '{pc: 32'hFFFF_FFF0, word: 32'h1000_0010, src: 1, j: 0, jr: 0, jra: 32'h0,        exp: 32'h0000_0034, lat: 1};
      vecs[6] = '{pc: 32'h0000_0060, word: 32'h0000_0008, src: 0, j: 0, jr: 1, jra: 32'h123,      exp: 32'h0000_0123, lat: 3};
      vecs[7] = '{pc: 32'h0000_0300, word: 32'h1000_0004, src: 0, j: 0, jr: 0, jra: 32'h999,      exp: 32'h0000_0304, lat: 2};

      // Sequential fetch with single-cycle memory and no stall
      mem_lat = 1;
      do_reset();
      for (int i = 0; i < 64; i++) sb_push(32'(4 * i));
      @(posedge clk); #1;
      check("t1_first_req", {31'd0, imem_req}, 32'd1);
      check("t1_first_addr", imem_addr, 32'd0);
      @(posedge clk); #1;
      check("t1_latency_valid", {31'd0, instr_valid}, 32'd1);
      check("t1_latency_pc", instr_pc, 32'd0);
      check("t1_pc_plus4", pc_plus4, 32'd4);
      stall = 1'b0;
      repeat (30) @(posedge clk);
      #1 stall = 1'b1;
      check("t1_takes_ge_20", {31'd0, sb_pops >= 20}, 32'd1);

      // Stall with slow memory: buffer fills, request drops, then resumes
      mem_lat = 3;
      do_reset();
      repeat (20) @(posedge clk);
      #1;
      check("t2_full_valid", {31'd0, instr_valid}, 32'd1);
      check("t2_full_no_req", {31'd0, imem_req}, 32'd0);
      check("t2_head_pc", instr_pc, 32'd0);
      for (int i = 0; i < 64; i++) sb_push(32'(4 * i));
      stall = 1'b0;
      held = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (imem_req) begin held = 1; break; end
      end
      check("t2_req_resumes", {31'd0, imem_req}, 32'd1);
      repeat (40) @(posedge clk);
      #1 stall = 1'b1;
      check("t2_takes_ge_10", {31'd0, sb_pops >= 10}, 32'd1);

      // Redirect table: jr from pc 0 to the vector pc, then take with its controls
      foreach (vecs[i]) begin
         ovr_addr = vecs[i].pc;
         ovr_word = vecs[i].word;
         mem_lat  = vecs[i].lat;
         do_reset();
         sb_push(32'd0);
         take_head(1'b0, 1'b0, 1'b1, vecs[i].pc);
         wait_valid("vec_head_valid");
         check("vec_head_pc", instr_pc, vecs[i].pc);
         check("vec_head_word", instr, vecs[i].word);
         check("vec_opcode", {26'd0, opcode}, {26'd0, vecs[i].word[31:26]});
         check("vec_func", {26'd0, func}, {26'd0, vecs[i].word[5:0]});
         sb_push(vecs[i].pc);
         take_head(vecs[i].src, vecs[i].j, vecs[i].jr, vecs[i].jra);
         wait_valid("vec_target_valid");
         check("vec_target_pc", instr_pc, vecs[i].exp);
         check("vec_target_word", instr, mem_word(vecs[i].exp));
         check("vec_target_plus4", pc_plus4, vecs[i].exp + 32'd4);
         check("vec_sb_drained", sb_q.size(), 32'd0);
      end
      ovr_addr = 32'hFFFF_FFFF;

      // Redirect while the request to 0x20 is outstanding
      mem_lat = 4;
      do_reset();
      sb_push(32'd0);
      take_head(1'b0, 1'b0, 1'b1, 32'h1C);
      wait_valid("t5_valid_1c");
      check("t5_head_1c", instr_pc, 32'h1C);
      check("t5_req_20", imem_addr, 32'h20);
      sb_push(32'h1C);
      take_head(1'b0, 1'b0, 1'b1, 32'h200);
      check("t5_drop_req", {31'd0, imem_req}, 32'd1);
      check("t5_drop_addr", imem_addr, 32'h20);
      check("t5_flushed", {31'd0, instr_valid}, 32'd0);
      held = 0;
      for (int i = 0; i < 10; i++) begin
         if (imem_addr !== 32'h20) break;
         held++;
         @(posedge clk); #1;
      end
      check("t5_new_addr", imem_addr, 32'h200);
      check("t5_new_req", {31'd0, imem_req}, 32'd1);
      wait_valid("t5_valid_200");
      check("t5_head_pc", instr_pc, 32'h200);
      check("t5_head_word", instr, mem_word(32'h200));

      // Asynchronous reset in the middle of an outstanding request
      mem_lat = 4;
      do_reset();
      wait_valid("t6_valid");
      check("t6_req_pending", {31'd0, imem_req}, 32'd1);
      #2 rst = 1'b0;
      #1;
      check("t6_req_dropped", {31'd0, imem_req}, 32'd0);
      check("t6_valid_dropped", {31'd0, instr_valid}, 32'd0);
      check("t6_addr_reset", imem_addr, 32'd0);
      check("t6_instr_reset", instr, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("t6_refetch_req", {31'd0, imem_req}, 32'd1);
      check("t6_refetch_addr", imem_addr, 32'd0);
      wait_valid("t6_refetch_valid");
      check("t6_refetch_pc", instr_pc, 32'd0);
      check("t6_refetch_word", instr, mem_word(32'd0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
